// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between the instruction-fetch port and the data port.
// Ports: ibus_* fetch side, dbus_* load/store side, m_* shared bus,
// flush_i/stallreq_o pipeline control, bus_err_o timeout pulse.
// Optional watchdog: define ARB_TIMEOUT_EN to abort hung transactions
// after TIMEOUT_CYCLES busy cycles.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ibus_req_i,
  input  logic [31:0] ibus_addr_i,
  output logic [31:0] ibus_data_o,
  output logic        ibus_ack_o,
  input  logic        dbus_req_i,
  input  logic        dbus_we_i,
  input  logic [3:0]  dbus_sel_i,
  input  logic [31:0] dbus_addr_i,
  input  logic [31:0] dbus_data_i,
  output logic [31:0] dbus_data_o,
  output logic        dbus_ack_o,
  output logic        m_req_o,
  output logic        m_we_o,
  output logic [3:0]  m_sel_o,
  output logic [31:0] m_addr_o,
  output logic [31:0] m_wdata_o,
  input  logic [31:0] m_rdata_i,
  input  logic        m_ack_i,
  input  logic        flush_i,
  output logic        stallreq_o,
  output logic        bus_err_o
);

  typedef enum logic [1:0] {
    IDLE,
    I_BUSY,
    D_BUSY
  } state_t;

  state_t state_q, state_d;
  logic   discard_q, discard_d;
  logic   d_go, i_go;
  logic   busy, done, kill, tmo;
  logic   i_drop, d_drop;

  // A requester still holds req during its ack cycle; masking with the
  // ack keeps that cycle from being taken as a fresh request.
  assign d_go = dbus_req_i & ~dbus_ack_o;
  assign i_go = ibus_req_i & ~ibus_ack_o;

  assign stallreq_o = rst & (i_go | d_go);

  assign busy   = (state_q != IDLE);
  assign i_drop = (state_q == I_BUSY) & (flush_i | ~ibus_req_i);
  assign d_drop = (state_q == D_BUSY) & ~dbus_req_i;
  assign kill   = discard_q | i_drop | d_drop;

`ifdef ARB_TIMEOUT_EN
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] cnt_q;

  // An ack in the last allowed cycle wins over the timeout.
  assign tmo = busy & ~m_ack_i & (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (!busy) begin
      cnt_q <= '0;
    end else if (!m_ack_i) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end
`else
  assign tmo = 1'b0;
`endif

  assign done = busy & (m_ack_i | tmo);

  always_comb begin
    state_d   = state_q;
    discard_d = discard_q;
    unique case (state_q)
      IDLE: begin
        discard_d = 1'b0;
        if (d_go) state_d = D_BUSY;
        else if (i_go) state_d = I_BUSY;
      end
      I_BUSY: begin
        if (done) begin
          state_d   = IDLE;
          discard_d = 1'b0;
        end else if (i_drop) begin
          discard_d = 1'b1;
        end
      end
      D_BUSY: begin
        if (done) begin
          state_d   = IDLE;
          discard_d = 1'b0;
        end else if (d_drop) begin
          discard_d = 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        discard_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      discard_q   <= 1'b0;
      m_req_o     <= 1'b0;
      m_we_o      <= 1'b0;
      m_sel_o     <= '0;
      m_addr_o    <= '0;
      m_wdata_o   <= '0;
      ibus_ack_o  <= 1'b0;
      ibus_data_o <= '0;
      dbus_ack_o  <= 1'b0;
      dbus_data_o <= '0;
      bus_err_o   <= 1'b0;
    end else begin
      state_q    <= state_d;
      discard_q  <= discard_d;
      ibus_ack_o <= 1'b0;
      dbus_ack_o <= 1'b0;
      bus_err_o  <= tmo;
      if (!busy) begin
        if (d_go) begin
          m_req_o   <= 1'b1;
          m_we_o    <= dbus_we_i;
          m_sel_o   <= dbus_sel_i;
          m_addr_o  <= dbus_addr_i;
          m_wdata_o <= dbus_data_i;
        end else if (i_go) begin
          m_req_o   <= 1'b1;
          m_we_o    <= 1'b0;
          m_sel_o   <= 4'hF;
          m_addr_o  <= ibus_addr_i;
          m_wdata_o <= '0;
        end
      end else if (done) begin
        m_req_o <= 1'b0;
        if (!kill) begin
          if (state_q == I_BUSY) begin
            ibus_ack_o  <= 1'b1;
            ibus_data_o <= tmo ? 32'h0 : m_rdata_i;
          end else begin
            dbus_ack_o  <= 1'b1;
            dbus_data_o <= tmo ? 32'h0 : m_rdata_i;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: per-cycle vector table plus
// hand-written reset and timeout sequences.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ibus_req_i;
  logic [31:0] ibus_addr_i;
  logic [31:0] ibus_data_o;
  logic        ibus_ack_o;
  logic        dbus_req_i;
  logic        dbus_we_i;
  logic [3:0]  dbus_sel_i;
  logic [31:0] dbus_addr_i;
  logic [31:0] dbus_data_i;
  logic [31:0] dbus_data_o;
  logic        dbus_ack_o;
  logic        m_req_o;
  logic        m_we_o;
  logic [3:0]  m_sel_o;
  logic [31:0] m_addr_o;
  logic [31:0] m_wdata_o;
  logic [31:0] m_rdata_i;
  logic        m_ack_i;
  logic        flush_i;
  logic        stallreq_o;
  logic        bus_err_o;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk),
    .rst(rst),
    .ibus_req_i(ibus_req_i),
    .ibus_addr_i(ibus_addr_i),
    .ibus_data_o(ibus_data_o),
    .ibus_ack_o(ibus_ack_o),
    .dbus_req_i(dbus_req_i),
    .dbus_we_i(dbus_we_i),
    .dbus_sel_i(dbus_sel_i),
    .dbus_addr_i(dbus_addr_i),
    .dbus_data_i(dbus_data_i),
    .dbus_data_o(dbus_data_o),
    .dbus_ack_o(dbus_ack_o),
    .m_req_o(m_req_o),
    .m_we_o(m_we_o),
    .m_sel_o(m_sel_o),
    .m_addr_o(m_addr_o),
    .m_wdata_o(m_wdata_o),
    .m_rdata_i(m_rdata_i),
    .m_ack_i(m_ack_i),
    .flush_i(flush_i),
    .stallreq_o(stallreq_o),
    .bus_err_o(bus_err_o)
  );

  typedef struct {
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic        dwe;
    logic [3:0]  dsel;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic        mack;
    logic [31:0] mrdata;
    logic        flush;
    logic        e_mreq;
    logic        e_mwe;
    logic [3:0]  e_msel;
    logic [31:0] e_maddr;
    logic [31:0] e_mwdata;
    logic        e_iack;
    logic [31:0] e_idata;
    logic        e_dack;
    logic [31:0] e_ddata;
    logic        e_stall;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    logic ireq, logic [31:0] iaddr,
    logic dreq, logic dwe, logic [3:0] dsel,
    logic [31:0] daddr, logic [31:0] dwdata,
    logic mack, logic [31:0] mrdata, logic flush,
    logic e_mreq, logic e_mwe, logic [3:0] e_msel,
    logic [31:0] e_maddr, logic [31:0] e_mwdata,
    logic e_iack, logic [31:0] e_idata,
    logic e_dack, logic [31:0] e_ddata, logic e_stall);
    vec_t v;
    v.ireq = ireq; v.iaddr = iaddr;
    v.dreq = dreq; v.dwe = dwe; v.dsel = dsel;
    v.daddr = daddr; v.dwdata = dwdata;
    v.mack = mack; v.mrdata = mrdata; v.flush = flush;
    v.e_mreq = e_mreq; v.e_mwe = e_mwe; v.e_msel = e_msel;
    v.e_maddr = e_maddr; v.e_mwdata = e_mwdata;
    v.e_iack = e_iack; v.e_idata = e_idata;
    v.e_dack = e_dack; v.e_ddata = e_ddata;
    v.e_stall = e_stall;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %h want %h", nm, act, exp);
    else
      passed++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ibus_req_i  = 1'b0;
    ibus_addr_i = '0;
    dbus_req_i  = 1'b0;
    dbus_we_i   = 1'b0;
    dbus_sel_i  = '0;
    dbus_addr_i = '0;
    dbus_data_i = '0;
    m_ack_i     = 1'b0;
    m_rdata_i   = '0;
    flush_i     = 1'b0;
  endtask

  initial begin
    // fetch @100, ack in 2nd bus cycle
    vecs.push_back(mk(1,'h100,0,0,0,0,0,0,0,0,
      1,0,4'hF,'h100,0,0,0,0,0,1));
    vecs.push_back(mk(1,'h100,0,0,0,0,0,0,0,0,
      1,0,4'hF,'h100,0,0,0,0,0,1));
    vecs.push_back(mk(1,'h100,0,0,0,0,0,1,'h3C01_1234,0,
      0,0,4'hF,'h100,0,1,'h3C01_1234,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,
      0,0,4'hF,'h100,0,0,'h3C01_1234,0,0,0));
    // simultaneous fetch + store: store first
    vecs.push_back(mk(1,'h200,1,1,4'b0011,'h40,'hDEAD_BEEF,0,0,0,
      1,1,4'b0011,'h40,'hDEAD_BEEF,0,'h3C01_1234,0,0,1));
    vecs.push_back(mk(1,'h200,1,1,4'b0011,'h40,'hDEAD_BEEF,1,'h1111_1111,0,
      0,1,4'b0011,'h40,'hDEAD_BEEF,0,'h3C01_1234,1,'h1111_1111,1));
    vecs.push_back(mk(1,'h200,1,1,4'b0011,'h40,'hDEAD_BEEF,0,0,0,
      1,0,4'hF,'h200,0,0,'h3C01_1234,0,'h1111_1111,1));
    vecs.push_back(mk(1,'h200,0,0,0,0,0,1,'hAAAA_5555,0,
      0,0,4'hF,'h200,0,1,'hAAAA_5555,0,'h1111_1111,0));
    // req still high in ack cycle must not re-grant
    vecs.push_back(mk(1,'h200,0,0,0,0,0,0,0,0,
      0,0,4'hF,'h200,0,0,'hAAAA_5555,0,'h1111_1111,1));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,
      0,0,4'hF,'h200,0,0,'hAAAA_5555,0,'h1111_1111,0));
    // flush during fetch
    vecs.push_back(mk(1,'h300,0,0,0,0,0,0,0,0,
      1,0,4'hF,'h300,0,0,'hAAAA_5555,0,'h1111_1111,1));
    vecs.push_back(mk(1,'h300,0,0,0,0,0,0,0,1,
      1,0,4'hF,'h300,0,0,'hAAAA_5555,0,'h1111_1111,1));
    vecs.push_back(mk(1,'h300,0,0,0,0,0,1,'hBAD0_BAD0,0,
      0,0,4'hF,'h300,0,0,'hAAAA_5555,0,'h1111_1111,1));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,
      0,0,4'hF,'h300,0,0,'hAAAA_5555,0,'h1111_1111,0));
    // flush during load: still acks
    vecs.push_back(mk(0,0,1,0,4'hF,'h80,0,0,0,0,
      1,0,4'hF,'h80,0,0,'hAAAA_5555,0,'h1111_1111,1));
    vecs.push_back(mk(0,0,1,0,4'hF,'h80,0,1,'h1234_5678,1,
      0,0,4'hF,'h80,0,0,'hAAAA_5555,1,'h1234_5678,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,
      0,0,4'hF,'h80,0,0,'hAAAA_5555,0,'h1234_5678,0));
    // dbus drops req mid-transaction
    vecs.push_back(mk(0,0,1,1,4'hC,'h84,'hCAFE_F00D,0,0,0,
      1,1,4'hC,'h84,'hCAFE_F00D,0,'hAAAA_5555,0,'h1234_5678,1));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,
      1,1,4'hC,'h84,'hCAFE_F00D,0,'hAAAA_5555,0,'h1234_5678,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,1,'h55,0,
      0,1,4'hC,'h84,'hCAFE_F00D,0,'hAAAA_5555,0,'h1234_5678,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,
      0,1,4'hC,'h84,'hCAFE_F00D,0,'hAAAA_5555,0,'h1234_5678,0));

    rst = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("rst mreq", 32'(m_req_o), 0);
    chk("rst iack", 32'(ibus_ack_o), 0);
    chk("rst dack", 32'(dbus_ack_o), 0);
    chk("rst maddr", m_addr_o, 0);
    chk("rst idata", ibus_data_o, 0);
    chk("rst ddata", dbus_data_o, 0);
    chk("rst err", 32'(bus_err_o), 0);
    ibus_req_i = 1'b1;
    #1;
    chk("rst stall", 32'(stallreq_o), 0);
    ibus_req_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step();

    foreach (vecs[i]) begin
      ibus_req_i  = vecs[i].ireq;
      ibus_addr_i = vecs[i].iaddr;
      dbus_req_i  = vecs[i].dreq;
      dbus_we_i   = vecs[i].dwe;
      dbus_sel_i  = vecs[i].dsel;
      dbus_addr_i = vecs[i].daddr;
      dbus_data_i = vecs[i].dwdata;
      m_ack_i     = vecs[i].mack;
      m_rdata_i   = vecs[i].mrdata;
      flush_i     = vecs[i].flush;
      step();
      chk($sformatf("v%0d mreq", i), 32'(m_req_o), 32'(vecs[i].e_mreq));
      chk($sformatf("v%0d mwe", i), 32'(m_we_o), 32'(vecs[i].e_mwe));
      chk($sformatf("v%0d msel", i), 32'(m_sel_o), 32'(vecs[i].e_msel));
      chk($sformatf("v%0d maddr", i), m_addr_o, vecs[i].e_maddr);
      chk($sformatf("v%0d mwdata", i), m_wdata_o, vecs[i].e_mwdata);
      chk($sformatf("v%0d iack", i), 32'(ibus_ack_o), 32'(vecs[i].e_iack));
      chk($sformatf("v%0d idata", i), ibus_data_o, vecs[i].e_idata);
      chk($sformatf("v%0d dack", i), 32'(dbus_ack_o), 32'(vecs[i].e_dack));
      chk($sformatf("v%0d ddata", i), dbus_data_o, vecs[i].e_ddata);
      chk($sformatf("v%0d stall", i), 32'(stallreq_o), 32'(vecs[i].e_stall));
      chk($sformatf("v%0d err", i), 32'(bus_err_o), 0);
    end

    // reset while a store is in flight
    idle_inputs();
    dbus_req_i  = 1'b1;
    dbus_we_i   = 1'b1;
    dbus_sel_i  = 4'hF;
    dbus_addr_i = 32'h90;
    dbus_data_i = 32'h1;
    step();
    chk("rb mreq", 32'(m_req_o), 1);
    #2;
    rst = 1'b0;
    #1;
    chk("ra mreq", 32'(m_req_o), 0);
    chk("ra dack", 32'(dbus_ack_o), 0);
    chk("ra iack", 32'(ibus_ack_o), 0);
    chk("ra stall", 32'(stallreq_o), 0);
    chk("ra ddata", dbus_data_o, 0);
    chk("ra maddr", m_addr_o, 0);
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;
    ibus_req_i  = 1'b1;
    ibus_addr_i = 32'h400;
    step();
    chk("rf mreq", 32'(m_req_o), 1);
    chk("rf maddr", m_addr_o, 32'h400);
    m_ack_i   = 1'b1;
    m_rdata_i = 32'h0BAD_C0DE;
    step();
    chk("rf iack", 32'(ibus_ack_o), 1);
    chk("rf idata", ibus_data_o, 32'h0BAD_C0DE);
    idle_inputs();
    step();
    chk("rf iack off", 32'(ibus_ack_o), 0);

`ifdef ARB_TIMEOUT_EN
    dbus_req_i  = 1'b1;
    dbus_sel_i  = 4'hF;
    dbus_addr_i = 32'hC0;
    step();
    m_ack_i   = 1'b1;
    m_rdata_i = 32'h7777_7777;
    step();
    chk("t0 ddata", dbus_data_o, 32'h7777_7777);
    idle_inputs();
    step();
    dbus_req_i  = 1'b1;
    dbus_sel_i  = 4'hF;
    dbus_addr_i = 32'hC4;
    step();
    chk("t1 grant", 32'(m_req_o), 1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("t1 busy%0d mreq", k), 32'(m_req_o), 1);
      chk($sformatf("t1 busy%0d err", k), 32'(bus_err_o), 0);
    end
    step();
    chk("t1 err", 32'(bus_err_o), 1);
    chk("t1 dack", 32'(dbus_ack_o), 1);
    chk("t1 ddata", dbus_data_o, 0);
    chk("t1 mreq", 32'(m_req_o), 0);
    dbus_req_i = 1'b0;
    step();
    chk("t1 err off", 32'(bus_err_o), 0);
    dbus_req_i = 1'b1;
    step();
    step();
    step();
    step();
    m_ack_i   = 1'b1;
    m_rdata_i = 32'h9999_0000;
    step();
    chk("t2 err", 32'(bus_err_o), 0);
    chk("t2 dack", 32'(dbus_ack_o), 1);
    chk("t2 ddata", dbus_data_o, 32'h9999_0000);
    idle_inputs();
    step();
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
